// File: rtl/hazard_ctrl_param.sv
// Decode-stage hazard controller: tracks in-flight destinations over DEPTH stages,
// raises load-use stalls, registers per-source bypass selects, squashes wrong-path slots and latches halt.
module hazard_ctrl_param #(
  parameter int NUM_SRC     = 2,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dec_valid,
  input  logic [NUM_SRC-1:0]          dec_rd_en,
  input  logic [NUM_SRC*ADDR_W-1:0]   dec_rd_addr,
  input  logic                        dec_we,
  input  logic [ADDR_W-1:0]           dec_dst,
  input  logic                        dec_is_load,
  input  logic                        dec_hlt,
  input  logic                        flow_change,
  input  logic                        ext_stall,
  output logic                        issue,
  output logic                        stall_fetch,
  output logic                        load_use,
  output logic [NUM_SRC*DEPTH-1:0]    byp_sel,
  output logic                        hlt_wb,
  output logic [DEPTH-1:0]            inflight_we
);

  localparam int FW = $clog2(FLUSH_SLOTS + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_SLOTS - 1);

  logic [DEPTH-1:0]                ent_v;
  logic [DEPTH-1:0]                ent_we;
  logic [DEPTH-1:0]                ent_ld;
  logic [DEPTH-1:0][ADDR_W-1:0]    ent_dst;
  logic [FW-1:0]                   flush_cnt;
  logic                            halt_latch;
  logic [DEPTH-1:0]                hlt_pipe;
  logic                            squash;
  logic                            hazard_any;
  logic [NUM_SRC*DEPTH-1:0]        byp_nxt;
  logic [NUM_SRC-1:0][ADDR_W-1:0]  src_addr;

  assign src_addr = dec_rd_addr;

  // Handshake: ID advances into EX exactly when issue=1; stall_fetch=1 holds PC and IM_ID.
  // A squashed slot is dropped (bubble) without stalling, so squash wins over load_use.
  assign squash = flow_change | (flush_cnt != '0) | halt_latch;

  always_comb begin
    hazard_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (dec_rd_en[i] && (src_addr[i] != '0) && ent_v[k] && ent_we[k] &&
            ent_ld[k] && (ent_dst[k] == src_addr[i]))
          hazard_any = 1'b1;
      end
    end
  end

  assign load_use    = dec_valid & ~squash & hazard_any;
  assign issue       = dec_valid & ~squash & ~load_use & ~ext_stall;
  assign stall_fetch = load_use | halt_latch | ext_stall;
  assign inflight_we = ent_v & ent_we;

  // Scan oldest to youngest so the youngest matching producer overwrites the row.
  always_comb begin
    byp_nxt = '0;
    if (issue) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (dec_rd_en[i] && (src_addr[i] != '0) && ent_v[k] && ent_we[k] &&
              (ent_dst[k] == src_addr[i])) begin
            byp_nxt[i*DEPTH +: DEPTH] = '0;
            byp_nxt[i*DEPTH + k]      = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v      <= '0;
      ent_we     <= '0;
      ent_ld     <= '0;
      ent_dst    <= '0;
      flush_cnt  <= '0;
      halt_latch <= 1'b0;
      hlt_pipe   <= '0;
      hlt_wb     <= 1'b0;
      byp_sel    <= '0;
    end else if (!ext_stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_v[k]   <= ent_v[k-1];
        ent_we[k]  <= ent_we[k-1];
        ent_ld[k]  <= ent_ld[k-1];
        ent_dst[k] <= ent_dst[k-1];
        hlt_pipe[k] <= hlt_pipe[k-1];
      end
      ent_v[0]   <= issue;
      ent_we[0]  <= issue & dec_we;
      ent_ld[0]  <= issue & dec_is_load;
      ent_dst[0] <= issue ? dec_dst : '0;
      // The halt marker rides alongside the entries; write-back is one stage past the last entry.
      hlt_pipe[0] <= issue & dec_hlt;
      hlt_wb      <= hlt_wb | hlt_pipe[DEPTH-1];
      if (issue && dec_hlt)
        halt_latch <= 1'b1;
      if (flow_change)
        flush_cnt <= FLUSH_INIT;
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
      byp_sel <= byp_nxt;
    end
  end

endmodule
